// File: rtl/pipe_addsub_if.sv
// Valid/ready bundle for the pipelined adder/subtractor: operation in, result out.
// The master modport is the producer/consumer side, slave is the arithmetic block.
interface pipe_addsub_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_i;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_o;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, x, y, c_i, sub, in_tag, out_ready,
        input  in_ready, out_valid, s, c_o, ovf, out_tag
    );

    modport slave (
        input  in_valid, x, y, c_i, sub, in_tag, out_ready,
        output in_ready, out_valid, s, c_o, ovf, out_tag
    );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice of the carry chain
// is resolved per stage, with operands, tag and valid travelling alongside.
module pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic          clk,
    input logic          rst,
    pipe_addsub_if.slave bus
);
    localparam int unsigned Stages    = WIDTH / CHUNK;
    localparam int unsigned LastStage = Stages - 1;

    if ((WIDTH % CHUNK) != 0) begin : g_param_check
        $error("pipe_addsub: WIDTH must be a multiple of CHUNK");
    end

    logic [WIDTH-1:0] a_q   [Stages];
    logic [WIDTH-1:0] a_d   [Stages];
    logic [WIDTH-1:0] b_q   [Stages];
    logic [WIDTH-1:0] b_d   [Stages];
    logic [WIDTH-1:0] s_q   [Stages];
    logic [WIDTH-1:0] s_d   [Stages];
    logic             c_q   [Stages];
    logic             c_d   [Stages];
    logic             v_q   [Stages];
    logic             v_d   [Stages];
    logic [TAG_W-1:0] tag_q [Stages];
    logic [TAG_W-1:0] tag_d [Stages];

    logic en;

    // Global stall: the whole pipe, bubbles included, moves only when the output slot frees.
    assign en          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = rst || en;

    for (genvar k = 0; k < Stages; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [TAG_W-1:0] tag_in;
        logic [CHUNK:0]   chunk_sum;

        if (k == 0) begin : g_head
            // Subtraction is x + ~y + ~c_i on the same carry chain.
            assign a_in   = bus.x;
            assign b_in   = bus.sub ? ~bus.y : bus.y;
            assign s_in   = '0;
            assign c_in   = bus.c_i ^ bus.sub;
            assign v_in   = bus.in_valid;
            assign tag_in = bus.in_tag;
        end else begin : g_body
            assign a_in   = a_q[k-1];
            assign b_in   = b_q[k-1];
            assign s_in   = s_q[k-1];
            assign c_in   = c_q[k-1];
            assign v_in   = v_q[k-1];
            assign tag_in = tag_q[k-1];
        end

        assign chunk_sum = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
                         + (CHUNK+1)'(c_in);

        assign a_d[k]   = a_in;
        assign b_d[k]   = b_in;
        assign s_d[k]   = (s_in & ~(WIDTH'({CHUNK{1'b1}}) << (k*CHUNK)))
                        | (WIDTH'(chunk_sum[CHUNK-1:0]) << (k*CHUNK));
        assign c_d[k]   = chunk_sum[CHUNK];
        assign v_d[k]   = v_in;
        assign tag_d[k] = tag_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < Stages; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                tag_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < Stages; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                v_q[k]   <= v_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign bus.out_valid = v_q[LastStage];
    assign bus.s         = s_q[LastStage];
    assign bus.c_o       = c_q[LastStage];
    assign bus.out_tag   = tag_q[LastStage];
    // a ^ b ^ s at the MSB recovers the carry into it; XOR with carry out gives overflow.
    assign bus.ovf       = a_q[LastStage][WIDTH-1] ^ b_q[LastStage][WIDTH-1]
                         ^ s_q[LastStage][WIDTH-1] ^ c_q[LastStage];
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and small random checks of pipe_addsub at 16/4 (four stages) and 8/8 (one stage).
module tb_pipe_addsub;
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic [3:0]  tag;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   acc_cyc = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_addsub_if #(.WIDTH(16), .TAG_W(4)) bus ();
    pipe_addsub_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

    pipe_addsub #(.WIDTH(16), .CHUNK(4), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_addsub #(.WIDTH(8), .CHUNK(8), .TAG_W(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic res_t mk(input logic [15:0] s, input logic c, input logic o,
                                input logic [3:0] tag);
        res_t r;
        r.s = s; r.c = c; r.o = o; r.tag = tag;
        return r;
    endfunction

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic ci,
                                   input logic sub, input logic [3:0] tag);
        logic [16:0] r;
        logic [15:0] yy;
        yy = sub ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'b0, sub ? ~ci : ci};
        return mk(r[15:0], r[16], (x[15] == yy[15]) && (r[15] != x[15]), tag);
    endfunction

    // Output monitor: in-order scoreboard plus stability check while stalled.
    logic        stall_prev = 1'b0;
    logic [15:0] s_prev;
    logic        c_prev, o_prev;
    logic [3:0]  tag_prev;

    always @(negedge clk) begin : mon
        res_t r;
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_s",   bus.s,       s_prev);
                check_eq("hold_c",   bus.c_o,     c_prev);
                check_eq("hold_ovf", bus.ovf,     o_prev);
                check_eq("hold_tag", bus.out_tag, tag_prev);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out_valid", bus.out_valid, 1'b0);
                end else begin
                    r = exp_q.pop_front();
                    check_eq("res_s",   bus.s,       r.s);
                    check_eq("res_c",   bus.c_o,     r.c);
                    check_eq("res_ovf", bus.ovf,     r.o);
                    check_eq("res_tag", bus.out_tag, r.tag);
                end
            end
            stall_prev <= bus.out_valid && !bus.out_ready;
            s_prev     <= bus.s;
            c_prev     <= bus.c_o;
            o_prev     <= bus.ovf;
            tag_prev   <= bus.out_tag;
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        input logic sub, input logic [3:0] tag, input res_t exp);
        bus.x = x; bus.y = y; bus.c_i = ci; bus.sub = sub; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc_cyc = cyc;
                exp_q.push_back(exp);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        check_eq("send_timeout", bus.in_ready, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_latency(input string tag, input int lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check_eq(tag, cyc - acc_cyc, lat);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        #1;
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic stream(input int gap);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] rx, ry;
                    rx = 16'($urandom());
                    ry = 16'($urandom());
                    send(rx, ry, i[0], i[1], 4'(i + 8), model(rx, ry, i[0], i[1], 4'(i + 8)));
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", bus.in_ready, !bus.out_valid);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("bp_drain");
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo);
        bus8.x = x; bus8.y = y; bus8.c_i = ci; bus8.sub = sub; bus8.in_tag = 4'hA;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check_eq("w8_valid", bus8.out_valid, 1'b1);
        check_eq("w8_s",     bus8.s,         es);
        check_eq("w8_c",     bus8.c_o,       ec);
        check_eq("w8_ovf",   bus8.ovf,       eo);
        check_eq("w8_tag",   bus8.out_tag,   4'hA);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.c_i = 1'b0; bus.sub = 1'b0;
        bus.in_tag = '0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.x = '0; bus8.y = '0; bus8.c_i = 1'b0; bus8.sub = 1'b0;
        bus8.in_tag = '0; bus8.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_s",         bus.s,         16'h0);
        check_eq("rst_c",         bus.c_o,       1'b0);
        check_eq("rst_ovf",       bus.ovf,       1'b0);
        check_eq("rst_tag",       bus.out_tag,   4'h0);
        @(posedge clk);
        #1;

        // Basic add and its latency.
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 4'd3, mk(16'h5555, 1'b0, 1'b0, 4'd3));
        expect_latency("t1_latency", 4);
        drain("t1_drain");

        // Carry across all chunks, signed overflow in both directions, borrow.
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 4'd1, mk(16'h0000, 1'b1, 1'b0, 4'd1));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 4'd2, mk(16'h7FFF, 1'b1, 1'b1, 4'd2));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd4, mk(16'h8000, 1'b0, 1'b1, 4'd4));
        send(16'h0000, 16'h0001, 1'b0, 1'b1, 4'd5, mk(16'hFFFF, 1'b0, 1'b0, 4'd5));
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd6, mk(16'h0000, 1'b1, 1'b0, 4'd6));
        drain("t3_drain");

        // Back-to-back random stream, one acceptance per cycle.
        begin
            int c0;
            c0 = cyc;
            for (int i = 0; i < 32; i++) begin
                logic [15:0] rx, ry;
                logic        rc, rs;
                rx = 16'($urandom());
                ry = 16'($urandom());
                rc = 1'($urandom());
                rs = 1'($urandom());
                send(rx, ry, rc, rs, 4'(i), model(rx, ry, rc, rs, 4'(i)));
            end
            check_eq("t4_throughput", cyc - c0, 32);
        end
        drain("t4_drain");

        // Backpressure, first dense then with bubbles.
        stream(0);
        stream(1);

        // Reset with three operations in flight, and one offered during reset.
        send(16'h0101, 16'h0202, 1'b0, 1'b0, 4'd7, mk(16'h0303, 1'b0, 1'b0, 4'd7));
        send(16'h1111, 16'h0001, 1'b0, 1'b1, 4'd8, mk(16'h1110, 1'b1, 1'b0, 4'd8));
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 4'd9, mk(16'h8000, 1'b0, 1'b1, 4'd9));
        rst = 1'b1;
        exp_q.delete();
        bus.x = 16'hAAAA; bus.y = 16'h5555; bus.in_tag = 4'hF; bus.in_valid = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_mid_s",         bus.s,         16'h0);
        repeat (6) @(posedge clk);
        #1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 4'd12, mk(16'h1000, 1'b0, 1'b0, 4'd12));
        expect_latency("rst_post_latency", 4);
        drain("rst_drain");

        // Single-stage instance: result the cycle after acceptance.
        op8(8'h12, 8'h43, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
        op8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
